fetch_pipe: RTL and testbench
=============================

# fetch_pipe

Parametrised, stall-capable instruction fetch stage for the pipelined LEGv8 core. It replaces the single-cycle PC/+4/branch-mux fetch. It adds:
- a wait-state handshake to instruction memory,
- exception redirect,
- stall and flush inputs from the hazard unit,
- an integrated IF/ID pipeline register.

It sits between the hazard/branch logic and the decode stage.

## Interface
Parameters:
- N, 64, address/PC width
- INSTR_W, 32, instruction width
- PC_INCR, 4, sequential PC increment in bytes
- RESET_PC, 0, PC value loaded on reset
- EXC_VECTOR, 'h100, exception redirect target

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- PCSrc_F  input  1  taken-branch redirect request
- PCBranch_F  input  N  branch target, valid when PCSrc_F=1
- Exc_F  input  1  exception redirect request; beats PCSrc_F
- Stall_D  input  1  decode cannot accept; hold PC and IF/ID
- Flush_D  input  1  invalidate IF/ID contents
- imem_ready_F  input  1  imem_data_F valid for the current imem_addr_F
- imem_data_F  input  INSTR_W  instruction returned by memory
- imem_addr_F  output  N  fetch address; equals PC register
- imem_req_F  output  1  fetch request
- instr_D  output  INSTR_W  IF/ID instruction
- pc_D  output  N  IF/ID PC of instr_D
- valid_D  output  1  IF/ID contents valid

## Operation
- State: PC register (N bits), FSM {FETCH, DRAIN}, pend_pc (N bits), IF/ID register (instr_D, pc_D, valid_D).
- redirect = Exc_F | PCSrc_F. target = Exc_F ? EXC_VECTOR : PCBranch_F.
- imem_req_F = !reset. imem_addr_F = PC.
- imem_addr_F stays stable while imem_ready_F=0. The PC never changes in a cycle without a response.
- PC arithmetic: PC + PC_INCR, truncated to N bits. Wraps from 2^N-PC_INCR to 0.

FETCH state, by priority:
1. redirect & imem_ready_F: response discarded; PC <= target; IF/ID bubble (valid_D <= 0).
2. redirect & !imem_ready_F: pend_pc <= target; PC held; go DRAIN; IF/ID bubble.
3. Stall_D: PC held; IF/ID held; response not consumed. Memory re-presents the same address next cycle.
4. imem_ready_F: instr_D <= imem_data_F; pc_D <= PC; valid_D <= 1; PC <= PC + PC_INCR.
5. Otherwise (wait state): PC held; valid_D <= 0.

DRAIN state (wrong-path access still outstanding):
- A new redirect overwrites pend_pc with the new target. Latest wins; Exc_F beats PCSrc_F in the same cycle.
- On imem_ready_F: response discarded. PC <= (redirect this cycle ? target : pend_pc). Go FETCH.
- valid_D = 0 throughout DRAIN. Stall_D is ignored for PC purposes.

Flush_D:
- valid_D <= 0; instr_D and pc_D <= 0.
- Overrides Stall_D hold and any capture that cycle.
- Does not by itself change the PC or the FSM.

Reset (any cycle, any state, including mid-wait or in DRAIN):
- PC <= RESET_PC; state <= FETCH; pend_pc <= 0.
- valid_D <= 0; instr_D <= 0; pc_D <= 0.
- imem_req_F = 0 while reset is high.

## Timing
- Zero-wait memory: one instruction per cycle. The instruction at PC appears on instr_D one cycle after imem_addr_F=PC.
- Redirect penalty with ready=1: one bubble. imem_addr_F = target on the next cycle.
- Redirect during a wait: imem_addr_F = target on the cycle after the stale response arrives.
- Stall_D adds no bubbles. Fetch resumes in the cycle after Stall_D falls.
- All outputs are registered except imem_addr_F (= PC register) and imem_req_F (= !reset, combinational).

## Test plan
- Reset, RESET_PC=0, ready=1 for 4 cycles → imem_addr_F 0,4,8,12. pc_D 0,4,8 one cycle behind; valid_D=1 from cycle 2.
- PCSrc_F=1, PCBranch_F='h40 at PC=8, ready=1 → next imem_addr_F='h40, valid_D=0 one cycle. Then pc_D='h40.
- ready=0 at PC=8; PCSrc_F pulse to 'h80, then Exc_F pulse; ready=1 two cycles later → data discarded. imem_addr_F=EXC_VECTOR next; valid_D=0 throughout.
- Stall_D=1 for 3 cycles at PC=12 → imem_addr_F=12 and instr_D/pc_D unchanged for 3 cycles. Then PC=16.
- Stall_D=1 and Flush_D=1 in the same cycle → valid_D=0, pc_D=0. Exc_F and PCSrc_F together → PC=EXC_VECTOR.
- N=8, PC='hFC, ready=1 → PC wraps to 0. Reset asserted in DRAIN → PC=RESET_PC, FETCH, pending target lost.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: hazard/branch controls, instruction memory handshake, IF/ID outputs.
// master = fetch stage, slave = surrounding core / memory.
interface fetch_if #(
  parameter int N       = 64,
  parameter int INSTR_W = 32
);
  logic               PCSrc_F;
  logic [N-1:0]       PCBranch_F;
  logic               Exc_F;
  logic               Stall_D;
  logic               Flush_D;
  logic               imem_ready_F;
  logic [INSTR_W-1:0] imem_data_F;
  logic [N-1:0]       imem_addr_F;
  logic               imem_req_F;
  logic [INSTR_W-1:0] instr_D;
  logic [N-1:0]       pc_D;
  logic               valid_D;

  modport master (
    input  PCSrc_F, PCBranch_F, Exc_F, Stall_D, Flush_D, imem_ready_F, imem_data_F,
    output imem_addr_F, imem_req_F, instr_D, pc_D, valid_D
  );

  modport slave (
    output PCSrc_F, PCBranch_F, Exc_F, Stall_D, Flush_D, imem_ready_F, imem_data_F,
    input  imem_addr_F, imem_req_F, instr_D, pc_D, valid_D
  );
endinterface

// File: rtl/fetch_pipe.sv
// Stall-capable LEGv8 fetch stage with wait-state imem handshake, branch/exception
// redirect, and an integrated IF/ID register.
module fetch_pipe #(
  parameter int           N          = 64,
  parameter int           INSTR_W    = 32,
  parameter int           PC_INCR    = 4,
  parameter logic [N-1:0] RESET_PC   = '0,
  parameter logic [N-1:0] EXC_VECTOR = N'('h100)
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t             state, state_n;
  logic [N-1:0]       pc, pc_n;
  logic [N-1:0]       pend_pc, pend_pc_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [N-1:0]       pcd_q, pcd_n;
  logic               valid_q, valid_n;

  logic               redirect;
  logic [N-1:0]       target;

  assign redirect = bus.Exc_F | bus.PCSrc_F;
  assign target   = bus.Exc_F ? EXC_VECTOR : bus.PCBranch_F;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pend_pc <= '0;
      instr_q <= '0;
      pcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
      instr_q <= instr_n;
      pcd_q   <= pcd_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    instr_n   = instr_q;
    pcd_n     = pcd_q;
    valid_n   = valid_q;

    case (state)
      FETCH: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (bus.imem_ready_F) begin
            pc_n = target;
          end else begin
            // Wrong-path access is still in flight; park the target until it returns.
            pend_pc_n = target;
            state_n   = DRAIN;
          end
        end else if (!bus.Stall_D) begin
          if (bus.imem_ready_F) begin
            instr_n = bus.imem_data_F;
            pcd_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc + N'(PC_INCR);
          end else begin
            valid_n = 1'b0;
          end
        end
      end
      DRAIN: begin
        valid_n = 1'b0;
        if (redirect) pend_pc_n = target;
        if (bus.imem_ready_F) begin
          pc_n    = redirect ? target : pend_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase

    if (bus.Flush_D) begin
      valid_n = 1'b0;
      instr_n = '0;
      pcd_n   = '0;
    end
  end

  assign bus.imem_addr_F = pc;
  assign bus.imem_req_F  = !reset;
  assign bus.instr_D     = instr_q;
  assign bus.pc_D        = pcd_q;
  assign bus.valid_D     = valid_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Runs a 64-bit and an 8-bit fetch_pipe in lockstep on directed then random stimulus,
// comparing both against a cycle-level reference model of the fetch rules.
module tb_fetch_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.N(64), .INSTR_W(32)) bus64 ();
  fetch_if #(.N(8),  .INSTR_W(32)) bus8 ();

  fetch_pipe #(.N(64), .INSTR_W(32)) dut64 (.clk(clk), .reset(reset), .bus(bus64.master));
  fetch_pipe #(.N(8),  .INSTR_W(32), .EXC_VECTOR(8'h80)) dut8 (.clk(clk), .reset(reset), .bus(bus8.master));

  typedef struct {
    logic        rst, pcsrc, exc, stall, flush, ready;
    logic [63:0] br;
    logic [31:0] data;
  } stim_t;

  typedef struct {
    logic [63:0] pc, pend, pcd;
    logic [31:0] instr;
    logic        drain, valid, known, req;
  } mstate_t;

  mstate_t m64, m8;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: next architectural state after one clock under stimulus t.
  function automatic mstate_t step(input mstate_t s, input stim_t t,
                                   input logic [63:0] mask, input logic [63:0] exc_v);
    mstate_t     n;
    logic        redir;
    logic [63:0] tgt;
    n     = s;
    redir = t.exc | t.pcsrc;
    tgt   = (t.exc ? exc_v : t.br) & mask;
    n.req = !t.rst;
    if (t.rst) begin
      n.pc = 0; n.pend = 0; n.pcd = 0; n.instr = 0;
      n.drain = 0; n.valid = 0; n.known = 1;
      return n;
    end
    if (s.drain) begin
      n.valid = 0; n.known = 0;
      if (redir) n.pend = tgt;
      if (t.ready) begin
        n.pc = redir ? tgt : s.pend;
        n.drain = 0;
      end
    end else if (redir) begin
      n.valid = 0; n.known = 0;
      if (t.ready) n.pc = tgt;
      else begin n.pend = tgt; n.drain = 1; end
    end else if (!t.stall) begin
      if (t.ready) begin
        n.valid = 1; n.known = 1; n.instr = t.data; n.pcd = s.pc;
        n.pc = (s.pc + 64'd4) & mask;
      end else begin
        n.valid = 0; n.known = 0;
      end
    end
    if (t.flush) begin
      n.valid = 0; n.instr = 0; n.pcd = 0; n.known = 1;
    end
    return n;
  endfunction

  task automatic drive(input stim_t t);
    reset              = t.rst;
    bus64.PCSrc_F      = t.pcsrc;  bus8.PCSrc_F      = t.pcsrc;
    bus64.PCBranch_F   = t.br;     bus8.PCBranch_F   = t.br[7:0];
    bus64.Exc_F        = t.exc;    bus8.Exc_F        = t.exc;
    bus64.Stall_D      = t.stall;  bus8.Stall_D      = t.stall;
    bus64.Flush_D      = t.flush;  bus8.Flush_D      = t.flush;
    bus64.imem_ready_F = t.ready;  bus8.imem_ready_F = t.ready;
    bus64.imem_data_F  = t.data;   bus8.imem_data_F  = t.data;
  endtask

  task automatic check_all();
    chk("addr64",  bus64.imem_addr_F, m64.pc);
    chk("req64",   64'(bus64.imem_req_F), 64'(m64.req));
    chk("valid64", 64'(bus64.valid_D), 64'(m64.valid));
    if (m64.known) begin
      chk("pcd64",   bus64.pc_D, m64.pcd);
      chk("instr64", 64'(bus64.instr_D), 64'(m64.instr));
    end
    chk("addr8",  64'(bus8.imem_addr_F), m8.pc);
    chk("valid8", 64'(bus8.valid_D), 64'(m8.valid));
    if (m8.known) begin
      chk("pcd8",   64'(bus8.pc_D), m8.pcd);
      chk("instr8", 64'(bus8.instr_D), 64'(m8.instr));
    end
  endtask

  // Apply t across one rising edge, advance the models, check at the falling edge.
  task automatic cyc(input stim_t t);
    drive(t);
    @(posedge clk);
    m64 = step(m64, t, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100);
    m8  = step(m8,  t, 64'hFF, 64'h80);
    @(negedge clk);
    check_all();
  endtask

  function automatic stim_t idle();
    stim_t t;
    t.rst = 0; t.pcsrc = 0; t.exc = 0; t.stall = 0; t.flush = 0; t.ready = 1;
    t.br = 0; t.data = $urandom;
    return t;
  endfunction

  initial begin
    stim_t t;
    m64 = '{default: '0};
    m8  = '{default: '0};
    @(negedge clk);

    // Reset then sequential zero-wait fetch.
    t = idle(); t.rst = 1; cyc(t);
    chk("rst_addr", bus64.imem_addr_F, 64'h0);
    chk("rst_valid", 64'(bus64.valid_D), 64'h0);
    repeat (3) cyc(idle());
    chk("seq_addr", bus64.imem_addr_F, 64'd12);
    chk("seq_pcd", bus64.pc_D, 64'd8);

    // Taken branch with ready: one bubble, then the target.
    t = idle(); t.pcsrc = 1; t.br = 64'h40; cyc(t);
    chk("br_addr", bus64.imem_addr_F, 64'h40);
    chk("br_bubble", 64'(bus64.valid_D), 64'h0);
    cyc(idle());
    chk("br_pcd", bus64.pc_D, 64'h40);

    // Redirects during a wait state: exception wins, stale response discarded.
    t = idle(); t.ready = 0; t.pcsrc = 1; t.br = 64'h80; cyc(t);
    t = idle(); t.ready = 0; t.exc = 1; cyc(t);
    chk("drain_hold", bus64.imem_addr_F, 64'h44);
    t = idle(); cyc(t);
    chk("drain_addr", bus64.imem_addr_F, 64'h100);
    chk("drain_valid", 64'(bus64.valid_D), 64'h0);

    // Stall holds PC and IF/ID; fetch resumes afterwards.
    cyc(idle());
    repeat (3) begin t = idle(); t.stall = 1; cyc(t); end
    chk("stall_addr", bus64.imem_addr_F, 64'h104);
    chk("stall_pcd", bus64.pc_D, 64'h100);
    cyc(idle());
    chk("resume_addr", bus64.imem_addr_F, 64'h108);

    // Flush beats stall; Exc_F beats PCSrc_F.
    t = idle(); t.stall = 1; t.flush = 1; cyc(t);
    chk("flush_valid", 64'(bus64.valid_D), 64'h0);
    chk("flush_pcd", bus64.pc_D, 64'h0);
    t = idle(); t.exc = 1; t.pcsrc = 1; t.br = 64'h200; cyc(t);
    chk("exc_prio", bus64.imem_addr_F, 64'h100);

    // 8-bit PC wrap.
    t = idle(); t.pcsrc = 1; t.br = 64'hFC; cyc(t);
    cyc(idle());
    chk("wrap8", 64'(bus8.imem_addr_F), 64'h0);

    // Reset while draining drops the pending target.
    t = idle(); t.ready = 0; t.pcsrc = 1; t.br = 64'h40; cyc(t);
    t = idle(); t.ready = 0; t.rst = 1; cyc(t);
    chk("rst_drain", bus64.imem_addr_F, 64'h0);
    cyc(idle());
    chk("rst_drain_next", bus64.imem_addr_F, 64'h4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      t.rst   = ($urandom_range(99) < 2);
      t.pcsrc = ($urandom_range(99) < 10);
      t.exc   = ($urandom_range(99) < 4);
      t.stall = ($urandom_range(99) < 20);
      t.flush = ($urandom_range(99) < 8);
      t.ready = ($urandom_range(99) < 70);
      t.br    = {$urandom, $urandom} & ~64'h3;
      t.data  = $urandom;
      cyc(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
